// File: rtl/mips_step_ctrl.sv
// rtl/mips_step_ctrl.sv - run/halt/single-step controller producing the MIPS core enable
//
// Re-times each rising edge of the divided clock into a one-cycle cpu_en pulse in
// the clk domain, gated by a run switch, a debounced step button and the core's
// halt request. A wrapping counter of issued pulses is exported for display/debug.
//
// Ports:
//   clk       in   system clock, all state updates on the rising edge
//   reset     in   asynchronous active-low reset, clears every flop
//   slow_clk  in   divided clock, asynchronous to clk (>=2 clk cycles per level)
//   run       in   raw run switch (level)
//   step_btn  in   raw step push button, active-high, bouncing
//   halt_req  in   halt request from the core (break/syscall), level, clk domain
//   cpu_en    out  registered one-cycle core enable
//   state     out  2'b00 HALT, 2'b01 RUN, 2'b10 STEP
//   cycles    out  number of cpu_en pulses issued, wraps silently

module mips_step_ctrl #(
    parameter int DB_WIDTH  = 16,
    parameter int DB_COUNT  = 50000,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 slow_clk,
    input  logic                 run,
    input  logic                 step_btn,
    input  logic                 halt_req,
    output logic                 cpu_en,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] cycles
);

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10
    } state_t;

    // Terminal count: the button must disagree with db_state for DB_COUNT
    // consecutive cycles, i.e. the counter sees 0..DB_COUNT-1.
    localparam logic [DB_WIDTH-1:0] DB_LAST = DB_WIDTH'(DB_COUNT - 1);

    // ------------------------------------------------------------------
    // Two-flop synchronisers plus the slow_clk edge-detect flop
    // ------------------------------------------------------------------
    logic sc_m, sc_s, sc_prev;
    logic run_m, run_s;
    logic btn_m, btn_s;
    logic tick;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sc_m    <= 1'b0;
            sc_s    <= 1'b0;
            sc_prev <= 1'b0;
            run_m   <= 1'b0;
            run_s   <= 1'b0;
            btn_m   <= 1'b0;
            btn_s   <= 1'b0;
        end else begin
            sc_m    <= slow_clk;
            sc_s    <= sc_m;
            sc_prev <= sc_s;
            run_m   <= run;
            run_s   <= run_m;
            btn_m   <= step_btn;
            btn_s   <= btn_m;
        end
    end

    // One cycle per slow_clk rising edge; the level-width guarantee on
    // slow_clk keeps successive ticks at least 4 cycles apart.
    assign tick = sc_s & ~sc_prev;

    // ------------------------------------------------------------------
    // Step button debounce: accept a new level only after it has been
    // stable for DB_COUNT cycles. Any return to the accepted level
    // restarts the count, so bounce never reaches db_state.
    // ------------------------------------------------------------------
    logic                db_state;
    logic                db_prev;
    logic [DB_WIDTH-1:0] db_cnt;
    logic                step_pulse;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            db_state <= 1'b0;
            db_prev  <= 1'b0;
            db_cnt   <= '0;
        end else begin
            db_prev <= db_state;
            if (btn_s == db_state) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_LAST) begin
                db_state <= btn_s;
                db_cnt   <= '0;
            end else begin
                db_cnt <= db_cnt + DB_WIDTH'(1);
            end
        end
    end

    // Press only; a debounced release produces nothing.
    assign step_pulse = db_state & ~db_prev;

    // ------------------------------------------------------------------
    // Run/halt/step FSM: state register, cpu_en register and cycle counter
    // ------------------------------------------------------------------
    state_t state_q, state_d;
    logic   cpu_en_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_HALT;
            cpu_en  <= 1'b0;
            cycles  <= '0;
        end else begin
            state_q <= state_d;
            cpu_en  <= cpu_en_d;
            if (cpu_en_d) begin
                cycles <= cycles + CNT_WIDTH'(1);
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HALT: begin
                if (run_s && !halt_req) begin
                    state_d = ST_RUN;
                end else if (!run_s && step_pulse) begin
                    state_d = ST_STEP;
                end
            end
            ST_RUN: begin
                if (!run_s || halt_req) begin
                    state_d = ST_HALT;
                end
            end
            ST_STEP: begin
                // halt_req is deliberately ignored so a break can be stepped past.
                if (tick) begin
                    state_d = ST_HALT;
                end
            end
            default: state_d = ST_HALT;
        endcase
    end

    // Output logic: a halt or switch-off in RUN wins over a same-cycle tick,
    // so the pulse is suppressed on the cycle the FSM leaves RUN.
    always_comb begin
        cpu_en_d = 1'b0;
        case (state_q)
            ST_RUN:  cpu_en_d = tick & run_s & ~halt_req;
            ST_STEP: cpu_en_d = tick;
            default: cpu_en_d = 1'b0;
        endcase
    end

    assign state = state_q;

endmodule
